// File: rtl/seq_gated_capture_path.sv
// Serial pattern detector that gates parallel data captures: one capture per match,
// or a burst of WIN_LEN consecutive captures when the match arrives in windowed mode.
module seq_gated_capture_path #(
    parameter int                DATA_W  = 16,
    parameter int                PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PATTERN = 4'b1010,
    parameter int                WIN_LEN = 4,
    parameter int                CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              mode,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr_cnt,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              match,
    output logic              busy,
    output logic [CNT_W-1:0]  match_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HUNT    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    localparam int FILL_W = $clog2(PAT_W + 1);
    // The window counter only has to reach WIN_LEN-2: the detect edge is capture #1.
    localparam int WIN_W  = (WIN_LEN > 2) ? $clog2(WIN_LEN - 1) : 1;
    localparam logic [WIN_W-1:0]  WIN_INIT = WIN_W'((WIN_LEN > 1) ? (WIN_LEN - 2) : 0);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_HIT = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    state_t             r_state;
    logic [PAT_W-1:0]   r_shift;
    logic [FILL_W-1:0]  r_fill;
    logic [WIN_W-1:0]   r_win;
    logic [DATA_W-1:0]  r_data_out;
    logic               r_out_valid;
    logic               r_match;
    logic [CNT_W-1:0]   r_match_cnt;

    logic               w_active;
    logic [PAT_W-1:0]   w_window;
    logic               w_filled;
    logic               w_detect;

    // Leaving IDLE and dropping en both count as inactive, so neither shifts a bit.
    assign w_active = en && (r_state != S_IDLE);
    assign w_window = {r_shift[PAT_W-2:0], bit_in};
    assign w_filled = (r_fill >= FILL_HIT);
    assign w_detect = w_active && bit_valid && w_filled && (w_window == PATTERN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_fill  <= '0;
        end else if (!w_active) begin
            r_shift <= '0;
            r_fill  <= '0;
        end else if (bit_valid) begin
            r_shift <= w_window;
            if (r_fill != FILL_MAX) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_win       <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_match     <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_match     <= w_detect;
            case (r_state)
                S_IDLE: begin
                    r_win <= '0;
                    if (en) begin
                        r_state <= S_HUNT;
                    end
                end
                S_HUNT: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                    end else if (w_detect) begin
                        r_data_out  <= data_in;
                        r_out_valid <= 1'b1;
                        if (mode && (WIN_LEN > 1)) begin
                            r_state <= S_CAPTURE;
                            r_win   <= WIN_INIT;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                        r_win   <= '0;
                    end else begin
                        r_data_out  <= data_in;
                        r_out_valid <= 1'b1;
                        if (r_win == '0) begin
                            r_state <= S_HUNT;
                        end else begin
                            r_win <= r_win - 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_win   <= '0;
                end
            endcase
        end
    end

    // Clear has priority over a coincident detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_match_cnt <= '0;
        end else if (clr_cnt) begin
            r_match_cnt <= '0;
        end else if (w_detect && (r_match_cnt != CNT_MAX)) begin
            r_match_cnt <= r_match_cnt + 1'b1;
        end
    end

    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;
    assign match     = r_match;
    assign busy      = (r_state == S_CAPTURE);
    assign match_cnt = r_match_cnt;

endmodule

// File: tb/tb_seq_gated_capture_path.sv
// Directed scenarios plus randomized traffic against a bit-history / captures-owed model.
module tb_seq_gated_capture_path;

    localparam int DATA_W  = 16;
    localparam int PAT_W   = 4;
    localparam logic [PAT_W-1:0] PATTERN = 4'b1010;
    localparam int WIN_LEN = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0, mode = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, clr_cnt = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] data_out, data_out2;
    logic out_valid, match, busy, out_valid2, match2, busy2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;

    int checks = 0;
    int failures = 0;

    // Reference model: enabled flag, recent valid bits, captures still owed in a window.
    bit          m_on;
    bit          hist[$];
    int          m_owed;
    logic [15:0] m_dout;
    bit          m_ov, m_mt;
    int          m_cnt, m_cnt2;

    int ov_seen, busy_seen, match_seen;

    always #5 clk = ~clk;

    seq_gated_capture_path #(.DATA_W(DATA_W), .PAT_W(PAT_W), .PATTERN(PATTERN),
                             .WIN_LEN(WIN_LEN), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .bit_in(bit_in),
        .bit_valid(bit_valid), .data_in(data_in), .clr_cnt(clr_cnt),
        .data_out(data_out), .out_valid(out_valid), .match(match),
        .busy(busy), .match_cnt(match_cnt)
    );

    seq_gated_capture_path #(.DATA_W(DATA_W), .PAT_W(PAT_W), .PATTERN(PATTERN),
                             .WIN_LEN(WIN_LEN), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .bit_in(bit_in),
        .bit_valid(bit_valid), .data_in(data_in), .clr_cnt(clr_cnt),
        .data_out(data_out2), .out_valid(out_valid2), .match(match2),
        .busy(busy2), .match_cnt(match_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_on = 0; hist.delete(); m_owed = 0; m_dout = '0;
        m_ov = 0; m_mt = 0; m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic model_edge();
        bit det;
        bit cap;
        int v;
        if (reset) begin
            model_reset();
            return;
        end
        det = 0;
        cap = 0;
        if (!en || !m_on) begin
            m_on = en;
            hist.delete();
            m_owed = 0;
        end else begin
            if (bit_valid && hist.size() == PAT_W - 1) begin
                v = 0;
                foreach (hist[i]) v = (v << 1) | int'(hist[i]);
                v = (v << 1) | int'(bit_in);
                det = (v == int'(PATTERN));
            end
            if (bit_valid) begin
                hist.push_back(bit_in);
                if (hist.size() > PAT_W - 1) void'(hist.pop_front());
            end
            if (m_owed > 0) begin
                cap = 1;
                m_owed--;
            end else if (det) begin
                cap = 1;
                if (mode && WIN_LEN > 1) m_owed = WIN_LEN - 1;
            end
        end
        m_ov = cap;
        m_mt = det;
        if (cap) m_dout = data_in;
        if (clr_cnt) begin
            m_cnt = 0; m_cnt2 = 0;
        end else if (det) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data_out"},   data_out,   m_dout);
        chk({tag, ".out_valid"},  out_valid,  m_ov);
        chk({tag, ".match"},      match,      m_mt);
        chk({tag, ".busy"},       busy,       (m_owed > 0));
        chk({tag, ".match_cnt"},  match_cnt,  m_cnt);
        chk({tag, ".match_cnt2"}, match_cnt2, m_cnt2);
        if (out_valid) ov_seen++;
        if (busy) busy_seen++;
        if (match) match_seen++;
    endtask

    task automatic cyc(input string tag, input bit e, input bit md, input bit bv,
                       input bit b, input logic [15:0] d, input bit clr);
        en = e; mode = md; bit_valid = bv; bit_in = b; data_in = d; clr_cnt = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Drop en for one edge (optionally clearing the counters) and re-enable.
    task automatic restart(input bit clr);
        cyc("off", 0, 0, 0, 0, 16'h0, clr);
        cyc("on",  1, 0, 0, 0, 16'h0, 0);
        ov_seen = 0; busy_seen = 0; match_seen = 0;
    endtask

    initial begin
        bit b;
        model_reset();
        reset = 1'b1;
        #12;
        chk("reset.data_out", data_out, 16'h0);
        chk("reset.out_valid", out_valid, 1'b0);
        chk("reset.busy", busy, 1'b0);
        chk("reset.match_cnt", match_cnt, 8'h0);
        reset = 1'b0;

        // V1: single capture
        cyc("v1.idle", 0, 0, 0, 0, 16'h0, 0);
        cyc("v1.on",   1, 0, 0, 0, 16'h0, 0);
        cyc("v1.b0",   1, 0, 1, 1, 16'h1111, 0);
        cyc("v1.b1",   1, 0, 1, 0, 16'h2222, 0);
        cyc("v1.b2",   1, 0, 1, 1, 16'h3333, 0);
        cyc("v1.b3",   1, 0, 1, 0, 16'hBEEF, 0);
        chk("v1.dout_beef", data_out, 16'hBEEF);
        chk("v1.ov", out_valid, 1'b1);
        chk("v1.match", match, 1'b1);
        chk("v1.cnt1", match_cnt, 8'd1);
        cyc("v1.hold", 1, 0, 0, 0, 16'h5555, 0);
        chk("v1.dout_held", data_out, 16'hBEEF);
        chk("v1.ov_low", out_valid, 1'b0);

        // V2: overlapping detects
        restart(1);
        for (int i = 0; i < 6; i++) cyc("v2.bit", 1, 0, 1, (i % 2) == 0, 16'(16'h0A00 + i), 0);
        cyc("v2.tail", 1, 0, 0, 0, 16'h0, 0);
        chk("v2.matches", match_seen, 2);
        chk("v2.cnt2", match_cnt, 8'd2);

        // V3: window of 4 with a detect inside it and mode toggled mid-window
        restart(1);
        cyc("v3.b0", 1, 1, 1, 1, 16'h0000, 0);
        cyc("v3.b1", 1, 1, 1, 0, 16'h0000, 0);
        cyc("v3.b2", 1, 1, 1, 1, 16'h0000, 0);
        for (int i = 0; i < 7; i++) begin
            cyc("v3.win", 1, (i != 2), (i < 3), (i % 2) == 1, 16'(16'h0010 + i), 0);
            if (i < 4) chk("v3.dout_seq", data_out, 16'(16'h0010 + i));
        end
        chk("v3.ov_cycles", ov_seen, 4);
        chk("v3.busy_cycles", busy_seen, 3);
        chk("v3.dout_final", data_out, 16'h0013);

        // V4: gaps between bits, then en dropped mid-window
        restart(1);
        cyc("v4.b0", 1, 0, 1, 1, 16'h0, 0);
        cyc("v4.g",  1, 0, 0, 0, 16'h0, 0);
        cyc("v4.b1", 1, 0, 1, 0, 16'h0, 0);
        cyc("v4.g",  1, 0, 0, 1, 16'h0, 0);
        cyc("v4.g",  1, 0, 0, 1, 16'h0, 0);
        cyc("v4.b2", 1, 0, 1, 1, 16'h0, 0);
        cyc("v4.b3", 1, 0, 1, 0, 16'h4444, 0);
        chk("v4.gap_match", match, 1'b1);
        restart(0);
        cyc("v4.w0", 1, 1, 1, 1, 16'h0, 0);
        cyc("v4.w1", 1, 1, 1, 0, 16'h0, 0);
        cyc("v4.w2", 1, 1, 1, 1, 16'h0, 0);
        cyc("v4.w3", 1, 1, 1, 0, 16'h7001, 0);
        cyc("v4.w4", 1, 1, 0, 0, 16'h7002, 0);
        cyc("v4.abort", 0, 1, 0, 0, 16'h7003, 0);
        chk("v4.abort_ov", out_valid, 1'b0);
        chk("v4.abort_busy", busy, 1'b0);
        chk("v4.abort_dout", data_out, 16'h7002);
        cyc("v4.reon", 1, 1, 0, 0, 16'h7004, 0);
        cyc("v4.nores", 1, 1, 0, 0, 16'h7005, 0);
        chk("v4.no_resume", out_valid, 1'b0);

        // V5: saturation of the 2-bit counter, clear beats detect
        restart(1);
        for (int i = 0; i < 12; i++) cyc("v5.bit", 1, 0, 1, (i % 2) == 0, 16'h0, 0);
        chk("v5.cnt8", match_cnt, 8'd5);
        chk("v5.cnt2_sat", match_cnt2, 2'd3);
        cyc("v5.b", 1, 0, 1, 1, 16'h0, 0);
        cyc("v5.clrdet", 1, 0, 1, 0, 16'h0, 1);
        chk("v5.clr_match", match, 1'b1);
        chk("v5.clr_cnt", match_cnt, 8'd0);
        chk("v5.clr_cnt2", match_cnt2, 2'd0);

        // V6: asynchronous reset mid-window, then fresh bits required
        restart(0);
        cyc("v6.b0", 1, 1, 1, 1, 16'h0, 0);
        cyc("v6.b1", 1, 1, 1, 0, 16'h0, 0);
        cyc("v6.b2", 1, 1, 1, 1, 16'h0, 0);
        cyc("v6.b3", 1, 1, 1, 0, 16'h1234, 0);
        chk("v6.busy_pre", busy, 1'b1);
        chk("v6.dout_pre", data_out, 16'h1234);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("v6.async");
        chk("v6.async_dout", data_out, 16'h0);
        cyc("v6.held", 1, 1, 0, 0, 16'h9999, 0);
        reset = 1'b0;
        cyc("v6.rel", 1, 0, 1, 1, 16'h9999, 0);
        chk("v6.rel_ov", out_valid, 1'b0);
        cyc("v6.f0", 1, 0, 1, 1, 16'h0, 0);
        cyc("v6.f1", 1, 0, 1, 0, 16'h0, 0);
        chk("v6.no_stale", match, 1'b0);
        cyc("v6.f2", 1, 0, 1, 1, 16'h0, 0);
        cyc("v6.f3", 1, 0, 1, 0, 16'h0, 0);
        chk("v6.fresh_match", match, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            b = ($urandom_range(0, 3) != 0) ? ~bit_in : bit_in;
            cyc("rand", ($urandom_range(0, 29) != 0), $urandom_range(0, 1),
                ($urandom_range(0, 3) != 0), b, 16'($urandom), ($urandom_range(0, 39) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
